// File: rtl/cmdspi_burst.sv
// cmdspi_burst - SPI (mode 3) slave that turns framed command bursts into
// single-cycle register strobes in the clk domain.
//
// Frame: header {wr, inc, addr[AW-1:0]} (AW+2 bits, MSB first), followed by
// one or more DW-bit data words while CSN stays low.  Writes pulse we with
// addr/wdat after every complete word; reads pulse re, capture rdat RD_LAT
// cycles later and shift it out on MISO starting at the next SCLK fall.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   CSN/SCLK/MOSI SPI inputs, asynchronous to clk (2-flop synchronised)
//   MISO          SPI serial data out, MSB first, 0 unless a read is active
//   we, re        one-cycle write / read-request strobes
//   addr          register address for we and re
//   wdat          write data, valid while we is high
//   rdat          read data, sampled exactly RD_LAT cycles after re
//   busy          high while a frame is in progress
module cmdspi_burst #(
   parameter int AW     = 6,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          CSN,
   input  logic          SCLK,
   input  logic          MOSI,
   output logic          MISO,
   output logic          we,
   output logic          re,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] wdat,
   input  logic [DW-1:0] rdat,
   output logic          busy
);

   localparam int HB   = AW + 2;
   localparam int MAXB = (HB > DW) ? HB : DW;
   localparam int CW   = $clog2(MAXB + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HDR   = 2'd1,
      WDATA = 2'd2,
      RDATA = 2'd3
   } state_t;

   state_t          state_r, next_state_s;
   logic            csn_meta_r, csn_sync_r, csn_prev_r;
   logic            sclk_meta_r, sclk_sync_r, sclk_prev_r;
   logic            mosi_meta_r, mosi_sync_r;
   logic [CW-1:0]   bit_cnt_r;
   logic [AW:0]     hdr_sr_r;
   logic [DW-1:0]   rx_sr_r, tx_sr_r, wdat_r;
   logic [AW-1:0]   addr_r;
   logic            inc_r, we_r, re_r, miso_r, busy_r;
   logic            pend_r;
   logic [2:0]      lat_cnt_r;
   logic            csn_fall_s, csn_rise_s, sclk_rise_s, sclk_fall_s;
   logic            hdr_done_s, word_done_s, busy_s, cap_s;

   // SCLK edges only count while the synchronised chip select is low, so an
   // SCLK rise arriving together with the CSN rise is ignored.
   assign csn_fall_s  = csn_prev_r & ~csn_sync_r;
   assign csn_rise_s  = ~csn_prev_r & csn_sync_r;
   assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r & ~csn_sync_r;
   assign sclk_fall_s = ~sclk_sync_r & sclk_prev_r & ~csn_sync_r;

   // Read data is captured RD_LAT cycles after the re pulse.
   assign cap_s = (RD_LAT == 0) ? re_r : (pend_r && (lat_cnt_r == 3'(RD_LAT)));

   assign MISO = miso_r;
   assign we   = we_r;
   assign re   = re_r;
   assign addr = addr_r;
   assign wdat = wdat_r;
   assign busy = busy_r;

   // Two-flop synchronisers plus previous-value flops for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         csn_meta_r  <= 1'b0;
         csn_sync_r  <= 1'b0;
         csn_prev_r  <= 1'b0;
         sclk_meta_r <= 1'b0;
         sclk_sync_r <= 1'b0;
         sclk_prev_r <= 1'b0;
         mosi_meta_r <= 1'b0;
         mosi_sync_r <= 1'b0;
      end else begin
         csn_meta_r  <= CSN;
         csn_sync_r  <= csn_meta_r;
         csn_prev_r  <= csn_sync_r;
         sclk_meta_r <= SCLK;
         sclk_sync_r <= sclk_meta_r;
         sclk_prev_r <= sclk_sync_r;
         mosi_meta_r <= MOSI;
         mosi_sync_r <= mosi_meta_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic; a CSN rise aborts from any state.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (csn_fall_s) next_state_s = HDR;
            else            next_state_s = IDLE;
         end
         HDR: begin
            if (csn_rise_s)      next_state_s = IDLE;
            else if (hdr_done_s) next_state_s = hdr_sr_r[AW] ? WDATA : RDATA;
            else                 next_state_s = HDR;
         end
         WDATA, RDATA: begin
            if (csn_rise_s) next_state_s = IDLE;
            else            next_state_s = state_r;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // FSM output decode: header/word completion and frame-active flag.
   always_comb begin
      hdr_done_s  = 1'b0;
      word_done_s = 1'b0;
      busy_s      = (next_state_s != IDLE);
      case (state_r)
         HDR: begin
            hdr_done_s = sclk_rise_s && (bit_cnt_r == CW'(HB - 1));
         end
         WDATA, RDATA: begin
            word_done_s = sclk_rise_s && (bit_cnt_r == CW'(DW - 1));
         end
         default: begin
            hdr_done_s  = 1'b0;
            word_done_s = 1'b0;
         end
      endcase
   end

   // Header decode, bit counting, write/read strobes and address stepping.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_r <= '0;
         hdr_sr_r  <= '0;
         rx_sr_r   <= '0;
         wdat_r    <= '0;
         addr_r    <= '0;
         inc_r     <= 1'b0;
         we_r      <= 1'b0;
         re_r      <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         we_r   <= 1'b0;
         re_r   <= 1'b0;
         busy_r <= busy_s;
         // A write burst steps the address once its strobe has been seen.
         if (we_r && inc_r) addr_r <= addr_r + AW'(1);
         case (state_r)
            HDR: begin
               if (hdr_done_s) begin
                  inc_r     <= hdr_sr_r[AW-1];
                  addr_r    <= {hdr_sr_r[AW-2:0], mosi_sync_r};
                  re_r      <= ~hdr_sr_r[AW];
                  bit_cnt_r <= '0;
               end else if (sclk_rise_s) begin
                  hdr_sr_r  <= {hdr_sr_r[AW-1:0], mosi_sync_r};
                  bit_cnt_r <= bit_cnt_r + CW'(1);
               end
            end
            WDATA: begin
               if (word_done_s) begin
                  wdat_r    <= {rx_sr_r[DW-2:0], mosi_sync_r};
                  we_r      <= 1'b1;
                  bit_cnt_r <= '0;
               end else if (sclk_rise_s) begin
                  rx_sr_r   <= {rx_sr_r[DW-2:0], mosi_sync_r};
                  bit_cnt_r <= bit_cnt_r + CW'(1);
               end
            end
            RDATA: begin
               // Read bursts step before the next re so it targets the new word.
               if (word_done_s) begin
                  if (inc_r) addr_r <= addr_r + AW'(1);
                  re_r      <= 1'b1;
                  bit_cnt_r <= '0;
               end else if (sclk_rise_s) begin
                  bit_cnt_r <= bit_cnt_r + CW'(1);
               end
            end
            default: begin
               bit_cnt_r <= '0;
               hdr_sr_r  <= '0;
            end
         endcase
      end
   end

   // Read latency counter, transmit shift register and MISO driver.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_r    <= 1'b0;
         lat_cnt_r <= 3'd0;
         tx_sr_r   <= '0;
         miso_r    <= 1'b0;
      end else if (state_r != RDATA) begin
         pend_r    <= 1'b0;
         lat_cnt_r <= 3'd0;
         tx_sr_r   <= '0;
         miso_r    <= 1'b0;
      end else begin
         if (cap_s) begin
            pend_r    <= 1'b0;
            lat_cnt_r <= 3'd0;
         end else if (re_r && (RD_LAT != 0)) begin
            pend_r    <= 1'b1;
            lat_cnt_r <= 3'd1;
         end else if (pend_r) begin
            lat_cnt_r <= lat_cnt_r + 3'd1;
         end
         if (cap_s)            tx_sr_r <= rdat;
         else if (sclk_fall_s) tx_sr_r <= {tx_sr_r[DW-2:0], 1'b0};
         if (csn_rise_s)       miso_r <= 1'b0;
         else if (sclk_fall_s) miso_r <= tx_sr_r[DW-1];
      end
   end

endmodule

// File: tb/tb_cmdspi_burst.sv
// Directed bench for cmdspi_burst: a default instance (AW=6, DW=32, RD_LAT=1)
// and a swept instance (AW=7, DW=16, RD_LAT=3) driven by a bit-banged SPI
// mode-3 master.  Strobes are logged by per-instance monitors that also
// model the read-data port, presenting valid rdat only in the exact cycle
// RD_LAT after each re.
module tb_cmdspi_burst;

   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   logic clk = 1'b0;
   logic rst;

   logic        csn0, sclk0, mosi0, miso0, we0, re0, busy0;
   logic [5:0]  addr0;
   logic [31:0] wdat0, rdat0;

   logic        csn1, sclk1, mosi1, miso1, we1, re1, busy1;
   logic [6:0]  addr1;
   logic [15:0] wdat1, rdat1;

   int n_vec = 0;
   int n_err = 0;
   int viol  = 0;

   logic [31:0] we_addr0[$], we_dat0[$], re_addr0[$];
   logic [31:0] we_addr1[$], we_dat1[$], re_addr1[$];
   logic [31:0] rdv0[4];
   logic [15:0] rdv1[4];
   int          ridx0, ridx1;
   logic [63:0] rx;

   always #5 clk = ~clk;

   cmdspi_burst u_dut0 (
      .clk(clk), .rst(rst), .CSN(csn0), .SCLK(sclk0), .MOSI(mosi0), .MISO(miso0),
      .we(we0), .re(re0), .addr(addr0), .wdat(wdat0), .rdat(rdat0), .busy(busy0)
   );

   cmdspi_burst #(.AW(7), .DW(16), .RD_LAT(LAT1)) u_dut1 (
      .clk(clk), .rst(rst), .CSN(csn1), .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1),
      .we(we1), .re(re1), .addr(addr1), .wdat(wdat1), .rdat(rdat1), .busy(busy1)
   );

   // Monitor and read-data responder for the default instance.
   initial begin
      int since;
      logic [31:0] cur;
      since = 99;
      cur   = 32'h0;
      rdat0 = 32'hFFFF_FFFF;
      forever begin
         @(posedge clk); #1;
         if (re0) begin
            since = 0;
            cur   = rdv0[ridx0 & 3];
            ridx0++;
            re_addr0.push_back(32'(addr0));
         end else if (since < 99) begin
            since++;
         end
         rdat0 = (since == LAT0) ? cur : ~cur;
         if (we0) begin
            we_addr0.push_back(32'(addr0));
            we_dat0.push_back(wdat0);
         end
         if ((we0 && re0) || ((we0 || re0) && !busy0)) viol++;
      end
   end

   // Monitor and read-data responder for the swept instance.
   initial begin
      int since;
      logic [15:0] cur;
      since = 99;
      cur   = 16'h0;
      rdat1 = 16'hFFFF;
      forever begin
         @(posedge clk); #1;
         if (re1) begin
            since = 0;
            cur   = rdv1[ridx1 & 3];
            ridx1++;
            re_addr1.push_back(32'(addr1));
         end else if (since < 99) begin
            since++;
         end
         rdat1 = (since == LAT1) ? cur : ~cur;
         if (we1) begin
            we_addr1.push_back(32'(addr1));
            we_dat1.push_back(32'(wdat1));
         end
         if ((we1 && re1) || ((we1 || re1) && !busy1)) viol++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int hp(input int sel);
      return (sel == 0) ? 8 : 9;
   endfunction

   task automatic set_csn(input int sel, input logic v);
      if (sel == 0) csn0 = v; else csn1 = v;
   endtask

   task automatic set_sclk(input int sel, input logic v);
      if (sel == 0) sclk0 = v; else sclk1 = v;
   endtask

   task automatic set_mosi(input int sel, input logic v);
      if (sel == 0) mosi0 = v; else mosi1 = v;
   endtask

   task automatic clear_logs();
      we_addr0.delete(); we_dat0.delete(); re_addr0.delete(); ridx0 = 0;
      we_addr1.delete(); we_dat1.delete(); re_addr1.delete(); ridx1 = 0;
   endtask

   task automatic csn_low(input int sel);
      set_csn(sel, 1'b0);
      repeat (hp(sel)) @(negedge clk);
   endtask

   task automatic csn_high(input int sel);
      repeat (hp(sel)) @(negedge clk);
      set_csn(sel, 1'b1);
      repeat (4 * hp(sel)) @(negedge clk);
   endtask

   // Shift n bits MSB first; MISO is sampled just before each rising edge.
   // With end_csn set, CSN rises together with the final SCLK rise.
   task automatic shift(input int sel, input int n, input logic [63:0] d,
                        input bit end_csn, output logic [63:0] r);
      int h;
      logic m;
      h = hp(sel);
      r = 64'h0;
      for (int i = n - 1; i >= 0; i--) begin
         set_sclk(sel, 1'b0);
         set_mosi(sel, d[i]);
         repeat (h) @(negedge clk);
         m = (sel == 0) ? miso0 : miso1;
         r = {r[62:0], m};
         set_sclk(sel, 1'b1);
         if (end_csn && (i == 0)) set_csn(sel, 1'b1);
         repeat (h) @(negedge clk);
      end
      if (end_csn) repeat (4 * h) @(negedge clk);
   endtask

   task automatic chk_we0(input int i, input logic [31:0] a, input logic [31:0] d);
      if (we_addr0.size() > i) begin
         chk($sformatf("we0_addr[%0d]", i), 64'(we_addr0[i]), 64'(a));
         chk($sformatf("we0_wdat[%0d]", i), 64'(we_dat0[i]), 64'(d));
      end else begin
         chk($sformatf("we0_present[%0d]", i), 64'(we_addr0.size()), 64'(i + 1));
      end
   endtask

   task automatic chk_re0(input int i, input logic [31:0] a);
      if (re_addr0.size() > i) chk($sformatf("re0_addr[%0d]", i), 64'(re_addr0[i]), 64'(a));
      else chk($sformatf("re0_present[%0d]", i), 64'(re_addr0.size()), 64'(i + 1));
   endtask

   initial begin
      rst = 1'b1;
      csn0 = 1'b1; sclk0 = 1'b1; mosi0 = 1'b0;
      csn1 = 1'b1; sclk1 = 1'b1; mosi1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rdv0[i] = 32'h0;
         rdv1[i] = 16'h0;
      end
      clear_logs();
      repeat (5) @(negedge clk);

      // Reset state.
      chk("rst_busy0",   64'(busy0), 64'h0);
      chk("rst_addr0",   64'(addr0), 64'h0);
      chk("rst_wdat0",   64'(wdat0), 64'h0);
      chk("rst_strobe0", 64'({we0, re0}), 64'h0);
      chk("rst_miso0",   64'(miso0), 64'h0);
      chk("rst_dut1",    64'({busy1, miso1, we1, re1, addr1, wdat1}), 64'h0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Single write: header 0x82, data 0x12345678.
      clear_logs();
      csn_low(0);
      chk("busy_in_frame", 64'(busy0), 64'h1);
      shift(0, 8, 64'h82, 1'b0, rx);
      shift(0, 32, 64'h1234_5678, 1'b0, rx);
      chk("wr_miso_quiet", rx, 64'h0);
      csn_high(0);
      chk("wr1_we_cnt", 64'(we_addr0.size()), 64'd1);
      chk("wr1_re_cnt", 64'(re_addr0.size()), 64'd0);
      chk_we0(0, 32'h2, 32'h1234_5678);
      chk("busy_after_frame", 64'(busy0), 64'h0);

      // Single read: header 0x01, rdat 0xA5A5A5A5.
      clear_logs();
      rdv0[0] = 32'hA5A5_A5A5;
      csn_low(0);
      shift(0, 8, 64'h01, 1'b0, rx);
      shift(0, 32, 64'h0, 1'b1, rx);
      chk("rd1_miso_word", rx, 64'hA5A5_A5A5);
      chk("rd1_re_cnt", 64'(re_addr0.size()), 64'd1);
      chk_re0(0, 32'h1);
      chk("rd1_we_cnt", 64'(we_addr0.size()), 64'd0);
      chk("rd1_miso_idle", 64'(miso0), 64'h0);

      // Burst write with increment and address wrap: header 0xFE.
      clear_logs();
      csn_low(0);
      shift(0, 8, 64'hFE, 1'b0, rx);
      shift(0, 32, 64'h1111_1111, 1'b0, rx);
      shift(0, 32, 64'h2222_2222, 1'b0, rx);
      shift(0, 32, 64'h3333_3333, 1'b0, rx);
      csn_high(0);
      chk("bw_we_cnt", 64'(we_addr0.size()), 64'd3);
      chk_we0(0, 32'h3E, 32'h1111_1111);
      chk_we0(1, 32'h3F, 32'h2222_2222);
      chk_we0(2, 32'h00, 32'h3333_3333);

      // Burst read without increment: header 0x05, two words.
      clear_logs();
      rdv0[0] = 32'h5A5A_5A5A;
      rdv0[1] = 32'hA5A5_A5A5;
      csn_low(0);
      shift(0, 8, 64'h05, 1'b0, rx);
      shift(0, 32, 64'h0, 1'b0, rx);
      chk("br_word0", rx, 64'h5A5A_5A5A);
      shift(0, 32, 64'h0, 1'b1, rx);
      chk("br_word1", rx, 64'hA5A5_A5A5);
      chk("br_re_cnt", 64'(re_addr0.size()), 64'd2);
      chk_re0(0, 32'h5);
      chk_re0(1, 32'h5);

      // Abort mid-header: four bits then CSN high.
      clear_logs();
      csn_low(0);
      shift(0, 4, 64'h8, 1'b0, rx);
      csn_high(0);
      chk("hdr_abort_strobes", 64'(we_addr0.size() + re_addr0.size()), 64'd0);

      // Abort after 20 data bits, then a clean write.
      clear_logs();
      csn_low(0);
      shift(0, 8, 64'h82, 1'b0, rx);
      shift(0, 20, 64'hDEADB, 1'b0, rx);
      csn_high(0);
      chk("data_abort_we_cnt", 64'(we_addr0.size()), 64'd0);
      clear_logs();
      csn_low(0);
      shift(0, 8, 64'h82, 1'b0, rx);
      shift(0, 32, 64'hDEAD_BEEF, 1'b0, rx);
      csn_high(0);
      chk("after_abort_we_cnt", 64'(we_addr0.size()), 64'd1);
      chk_we0(0, 32'h2, 32'hDEAD_BEEF);

      // Reset mid-frame with CSN held low: the rest of the frame is ignored.
      clear_logs();
      csn_low(0);
      shift(0, 8, 64'h82, 1'b0, rx);
      shift(0, 10, 64'h155, 1'b0, rx);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mid_busy", 64'(busy0), 64'h0);
      shift(0, 32, 64'hCAFE_F00D, 1'b0, rx);
      csn_high(0);
      chk("rst_mid_we_cnt", 64'(we_addr0.size()), 64'd0);

      // Swept instance: read with increment from 0x7F wrapping to 0x00.
      clear_logs();
      rdv1[0] = 16'hBEEF;
      rdv1[1] = 16'h1234;
      csn_low(1);
      shift(1, 9, 64'h0FF, 1'b0, rx);
      shift(1, 16, 64'h0, 1'b0, rx);
      chk("p_rd_word0", rx, 64'hBEEF);
      shift(1, 16, 64'h0, 1'b1, rx);
      chk("p_rd_word1", rx, 64'h1234);
      chk("p_re_cnt", 64'(re_addr1.size()), 64'd2);
      if (re_addr1.size() == 2) begin
         chk("p_re_addr0", 64'(re_addr1[0]), 64'h7F);
         chk("p_re_addr1", 64'(re_addr1[1]), 64'h00);
      end

      // Swept instance: write 0xC3A5 to 0x15.
      clear_logs();
      csn_low(1);
      shift(1, 9, 64'h115, 1'b0, rx);
      shift(1, 16, 64'hC3A5, 1'b0, rx);
      csn_high(1);
      chk("p_we_cnt", 64'(we_addr1.size()), 64'd1);
      if (we_addr1.size() == 1) begin
         chk("p_we_addr", 64'(we_addr1[0]), 64'h15);
         chk("p_we_wdat", 64'(we_dat1[0]), 64'hC3A5);
      end

      // Strobes were never simultaneous and never outside a frame.
      chk("strobe_rules", 64'(viol), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
